// File: rtl/common.sv
// Shared fetch types, RISC-V opcode constants and static branch prediction helpers.
package common;

  typedef logic [31:0] instruction_type;

  typedef struct packed {
    logic        predict_taken;
    logic [31:0] predict_target;
  } branch_predict_type;

  typedef struct packed {
    instruction_type    instr;
    logic [31:0]        pc;
    branch_predict_type branch;
  } fq_entry_t;

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} fetch_state_e;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  function automatic logic [31:0] imm_b(input instruction_type i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input instruction_type i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  // Static rule: JAL and backward conditional branches are predicted taken.
  function automatic branch_predict_type predict(input instruction_type i,
                                                 input logic [31:0] pc_in);
    branch_predict_type bp;
    bp.predict_taken  = 1'b0;
    bp.predict_target = pc_in + 32'd4;
    if (i[6:0] == OPC_JAL) begin
      bp.predict_taken  = 1'b1;
      bp.predict_target = pc_in + imm_j(i);
    end else if (i[6:0] == OPC_BRANCH && imm_b(i)[12]) begin
      bp.predict_taken  = 1'b1;
      bp.predict_target = pc_in + imm_b(i);
    end
    return bp;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched instructions; simultaneous push and pop on a full queue both succeed.
module fetch_queue
  import common::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  fq_entry_t                data_i,
  output fq_entry_t                head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding imem requester with static prediction and a small fetch queue.
// state | meaning
// FETCH | request fetch_pc when queue has room
// WAIT  | request granted, waiting for read data
// DRAIN | flushed while a response is owed; discard it
module fetch_stage
  import common::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               stall,
  input  logic               flush,
  input  logic [31:0]        redirect_pc,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic               out_valid,
  output instruction_type    instruction,
  output logic [31:0]        pc,
  output branch_predict_type branch_out
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e       state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]      count;
  logic               push, pop;
  fq_entry_t          head;
  branch_predict_type rsp_pred;

  assign rsp_pred = predict(imem_rdata, fetch_pc_q);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    imem_req   = 1'b0;
    push       = 1'b0;
    if (flush) fetch_pc_d = {redirect_pc[31:2], 2'b00};
    case (state_q)
      FETCH: begin
        imem_req = rstn && !flush && (count < CW'(FQ_DEPTH));
        if (flush) begin
          if (imem_gnt) state_d = DRAIN;
        end else if (imem_req && imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = imem_rvalid ? FETCH : DRAIN;
        end else if (imem_rvalid) begin
          push       = 1'b1;
          fetch_pc_d = rsp_pred.predict_target;
          state_d    = FETCH;
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign pop = out_valid && !stall;

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ('{instr: imem_rdata, pc: fetch_pc_q, branch: rsp_pred}),
    .head_o  (head),
    .count_o (count)
  );

  assign imem_addr   = fetch_pc_q;
  assign out_valid   = (count != '0);
  assign instruction = head.instr;
  assign pc          = head.pc;
  assign branch_out  = head.branch;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, hand-written reset sequence, random traffic vs a program-flow model.
module tb_fetch_stage;
  import common::*;

  logic               clk = 1'b0;
  logic               rstn, stall, flush, imem_gnt, imem_rvalid;
  logic [31:0]        redirect_pc, imem_rdata, imem_addr, pc;
  logic               imem_req, out_valid;
  instruction_type    instruction;
  branch_predict_type branch_out;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .instruction(instruction), .pc(pc), .branch_out(branch_out)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ = 32'hFE00_0CE3;  // beq x0,x0,-8
  localparam logic [31:0] JAL = 32'h0100_006F;  // jal x0,+16

  typedef struct {
    logic        stall, flush;
    logic [31:0] redir;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_taken;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic v(input logic s, input logic f, input logic [31:0] r, input logic g,
                   input logic rv, input logic [31:0] rd, input logic er,
                   input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                   input logic et, input logic [31:0] eg);
    vq.push_back('{s, f, r, g, rv, rd, er, ea, ev, ep, et, eg});
  endtask

  // Predicted successor computed by adding up the immediate fields arithmetically.
  function automatic branch_predict_type ref_predict(input logic [31:0] ins, input logic [31:0] p);
    logic [31:0] off;
    branch_predict_type r;
    r.predict_taken  = 1'b0;
    r.predict_target = p + 32'd4;
    if (ins[6:0] == 7'b1101111) begin
      off = 32'(ins[30:21]) * 2 + 32'(ins[20]) * 2048 + 32'(ins[19:12]) * 4096;
      if (ins[31]) off = off - 32'd1048576;
      r.predict_taken  = 1'b1;
      r.predict_target = p + off;
    end else if (ins[6:0] == 7'b1100011 && ins[31]) begin
      off = 32'(ins[11:8]) * 2 + 32'(ins[30:25]) * 32 + 32'(ins[7]) * 2048 - 32'd4096;
      r.predict_taken  = 1'b1;
      r.predict_target = p + off;
    end
    return r;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B1) ^ (a >> 7);
    case (h[2:0])
      3'd0:       return {h[31:7], 7'b1101111};
      3'd1, 3'd2: return {h[31:7], 7'b1100011};
      default:    return {h[31:7], 7'b0010011};
    endcase
  endfunction

  logic        pend, prev_req, prev_gnt, prev_flush;
  logic [31:0] pend_addr, prev_addr, exp_pc;
  int          lat, n_deq;
  branch_predict_type bp;

  initial begin
    rstn = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // cycle-by-cycle directed scenarios
    v(0,0,0,1,0,0,          1,0,          0,0,0,0);
    v(0,0,0,0,1,NOP,        0,0,          0,0,0,0);
    v(0,0,0,1,0,0,          1,4,          1,0,0,4);
    v(0,0,0,0,1,NOP,        0,0,          0,0,0,0);
    v(0,0,0,1,0,0,          1,8,          1,4,0,8);
    v(0,0,0,0,1,NOP,        0,0,          0,0,0,0);
    v(0,0,0,0,0,0,          1,12,         1,8,0,12);
    v(0,1,32'h100,0,0,0,    0,0,          0,0,0,0);
    v(0,0,0,1,0,0,          1,32'h100,    0,0,0,0);
    v(0,0,0,0,1,BEQ,        0,0,          0,0,0,0);
    v(1,0,0,1,0,0,          1,32'hF8,     1,32'h100,1,32'hF8);
    v(1,0,0,0,1,NOP,        0,0,          1,32'h100,1,32'hF8);
    for (int i = 0; i < 3; i++) v(1,0,0,0,0,0, 0,0, 1,32'h100,1,32'hF8);
    v(0,0,0,0,0,0,          0,0,          1,32'h100,1,32'hF8);
    v(0,0,0,1,0,0,          1,32'hFC,     1,32'hF8,0,32'hFC);
    v(0,1,32'h203,0,0,0,    0,0,          0,0,0,0);
    v(0,0,0,0,0,0,          0,0,          0,0,0,0);
    v(0,0,0,0,1,NOP,        0,0,          0,0,0,0);
    v(0,0,0,1,0,0,          1,32'h200,    0,0,0,0);
    v(0,0,0,0,1,NOP,        0,0,          0,0,0,0);
    v(0,0,0,0,0,0,          1,32'h204,    1,32'h200,0,32'h204);
    v(0,0,0,0,0,0,          1,32'h204,    0,0,0,0);
    v(0,1,32'h300,0,0,0,    0,0,          0,0,0,0);
    v(0,0,0,0,0,0,          1,32'h300,    0,0,0,0);
    v(0,0,0,0,0,0,          1,32'h300,    0,0,0,0);
    v(0,1,32'hFFFF_FFFF,0,0,0, 0,0,       0,0,0,0);
    v(0,0,0,1,0,0,          1,32'hFFFF_FFFC, 0,0,0,0);
    v(0,0,0,0,1,NOP,        0,0,          0,0,0,0);
    v(0,0,0,0,0,0,          1,0,          1,32'hFFFF_FFFC,0,0);
    v(0,0,0,1,0,0,          1,0,          0,0,0,0);
    v(0,0,0,0,1,JAL,        0,0,          0,0,0,0);
    v(0,0,0,1,0,0,          1,32'h10,     1,0,1,32'h10);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_instr", instruction, 0);
    chk("rst_pc", pc, 0);
    chk("rst_branch", 32'(branch_out.predict_taken) | branch_out.predict_target, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("first_req", 32'(imem_req), 1);
    chk("first_addr", imem_addr, 32'h0);

    foreach (vq[i]) begin
      @(negedge clk);
      stall = vq[i].stall; flush = vq[i].flush; redirect_pc = vq[i].redir;
      imem_gnt = vq[i].gnt; imem_rvalid = vq[i].rvalid; imem_rdata = vq[i].rdata;
      #1;
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vq[i].e_req));
      if (vq[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, vq[i].e_addr);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vq[i].e_valid));
      if (vq[i].e_valid) begin
        chk($sformatf("v%0d_pc", i), pc, vq[i].e_pc);
        chk($sformatf("v%0d_taken", i), 32'(branch_out.predict_taken), 32'(vq[i].e_taken));
        chk($sformatf("v%0d_target", i), branch_out.predict_target, vq[i].e_tgt);
      end
    end

    // reset while a request is outstanding; its response arrives during and after reset
    @(negedge clk);
    rstn = 1'b0; stall = 1'b0; flush = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = NOP;
    #1;
    chk("mid_rst_req", 32'(imem_req), 0);
    @(negedge clk);
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_instr", instruction, 0);
    chk("mid_rst_target", branch_out.predict_target, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post_rst_req", 32'(imem_req), 1);
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_valid", 32'(out_valid), 0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    chk("stale_rsp_dropped", 32'(out_valid), 0);
    chk("stale_rsp_req", 32'(imem_req), 1);

    // random traffic: delivered instructions must follow the predicted program flow
    pend = 1'b0; pend_addr = '0; lat = 0; n_deq = 0; exp_pc = 32'h0;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_flush = 1'b0; prev_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      imem_rvalid = 1'b0; imem_rdata = '0;
      if (pend) begin
        if (lat == 0) begin
          imem_rvalid = 1'b1; imem_rdata = mem_word(pend_addr); pend = 1'b0;
        end else lat--;
      end
      stall = ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      imem_gnt = !flush && ($urandom_range(0, 9) < 6);
      #1;
      if (prev_flush) chk("rnd_flush_empty", 32'(out_valid), 0);
      if (flush || pend || imem_rvalid) chk("rnd_req_idle", 32'(imem_req), 0);
      if (prev_req && !prev_gnt && !flush) begin
        chk("rnd_req_hold", 32'(imem_req), 1);
        chk("rnd_addr_hold", imem_addr, prev_addr);
      end
      if (out_valid && !stall && !flush) begin
        bp = ref_predict(mem_word(exp_pc), exp_pc);
        chk("rnd_pc", pc, exp_pc);
        chk("rnd_instr", instruction, mem_word(exp_pc));
        chk("rnd_taken", 32'(branch_out.predict_taken), 32'(bp.predict_taken));
        chk("rnd_target", branch_out.predict_target, bp.predict_target);
        exp_pc = bp.predict_target;
        n_deq++;
      end
      if (flush) exp_pc = {redirect_pc[31:2], 2'b00};
      if (imem_req && imem_gnt) begin
        pend = 1'b1; pend_addr = imem_addr; lat = $urandom_range(0, 2);
      end
      prev_req = imem_req; prev_gnt = imem_gnt; prev_addr = imem_addr; prev_flush = flush;
    end
    chk("rnd_progress", 32'(n_deq > 100), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FQ_DEPTH, default 2, fetch-queue entries (power of two, >=2).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 stall  input  1  decode cannot accept; holds queue head.
REQ-006 flush  input  1  redirect from execute; discards all queued/in-flight fetches.
REQ-007 redirect_pc  input  32  new fetch address, valid when flush=1.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  32  word-aligned read address.
REQ-010 imem_gnt  input  1  request accepted this cycle.
REQ-011 imem_rvalid  input  1  read data valid.
REQ-012 imem_rdata  input  32  read data.
REQ-013 out_valid  output  1  instruction/pc/branch_out valid to decode.
REQ-014 instruction  output  instruction_type  queue-head instruction.
REQ-015 pc  output  32  address of instruction.
REQ-016 branch_out  output  branch_predict_type  prediction (predict_taken, predict_target) for instruction.

Function
REQ-017 FSM states FETCH, WAIT, DRAIN; at most one request outstanding.
REQ-018 FETCH: imem_req=1 when queue count < FQ_DEPTH and flush=0; imem_addr=fetch_pc; on imem_gnt go WAIT.
REQ-019 imem_addr shall stay stable while imem_req=1 and imem_gnt=0, unless flush=1.
REQ-020 WAIT: on imem_rvalid enqueue {imem_rdata, fetch_pc, prediction}, update fetch_pc, go FETCH; response latency arbitrary (>=1 cycle).
REQ-021 Prediction on rdata: opcode 7'b1101111 (JAL) -> taken, target fetch_pc+imm_j; opcode 7'b1100011 with imm_b[12]=1 -> taken, target fetch_pc+imm_b; else not taken, target fetch_pc+4.
REQ-022 Next fetch_pc = predict_target; all PC arithmetic modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-023 out_valid = queue non-empty; head dequeued on out_valid=1 and stall=0; outputs hold while stall=1.
REQ-024 Enqueue and dequeue in same cycle on full queue shall both succeed (count unchanged).
REQ-025 flush: queue emptied next cycle (out_valid=0), fetch_pc = {redirect_pc[31:2],2'b00}; flush overrides stall, enqueue and dequeue.
REQ-026 flush in FETCH with imem_gnt=0 -> stay FETCH, request reissued next cycle at redirect address.
REQ-027 flush in FETCH with imem_gnt=1, or in WAIT without imem_rvalid -> DRAIN.
REQ-028 flush in WAIT with imem_rvalid=1 -> response discarded, go FETCH.
REQ-029 DRAIN: imem_req=0; next imem_rvalid discarded, go FETCH; further flush in DRAIN updates fetch_pc only.

Reset
REQ-030 rstn=0 at posedge: state FETCH, fetch_pc=RESET_PC, queue empty, out_valid=0, imem_req=0, instruction=0, pc=0, branch_out=0.
REQ-031 First imem_req=1 in first cycle after rstn deasserts.
REQ-032 Reset mid-transaction shall abandon the outstanding request; responses arriving during or after reset for it are ignored (DRAIN not entered).

Structure
REQ-033 instruction_type, branch_predict_type, opcode constants and immediate-extract functions (imm_b, imm_j) live in shared package common.
REQ-034 One sub-module fetch_queue (parameterised FQ_DEPTH circular buffer, push/pop/flush, count) is instantiated.

Verification
REQ-035 Reset, imem_gnt=1, rvalid one cycle later, stall=0 -> imem_addr sequence 0,4,8; pc outputs 0,4,8 with predict_taken=0.
REQ-036 rdata at pc 32'h100 = BEQ offset -8 -> branch_out={1,32'hF8}; next imem_addr 32'hF8.
REQ-037 stall=1 for 5 cycles -> queue fills to 2, imem_req=0, head held; stall release -> 2 consecutive dequeues, fetch resumes.
REQ-038 flush with redirect_pc 32'h203 while in WAIT -> DRAIN, late rvalid dropped, next imem_addr 32'h200, out_valid=0 until new response.
REQ-039 fetch_pc 32'hFFFF_FFFC, non-branch -> next imem_addr 32'h0.
REQ-040 imem_gnt=0 for 3 cycles -> imem_req and imem_addr stable throughout; flush in cycle 2 -> address changes to redirect.
